div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
//  Drives ex_ok_o into stall_flush_controller: low while a divide is pending, freezing the whole pipe.
//  Results (lo=quotient, hi=remainder) go to the HI/LO write path in EX.
//  Cancels an in-flight divide on an exception flush.
// PARAMETERS
//  DATA_W  32  operand/result width; iteration count equals DATA_W
// PORTS
//  clk               in   1       system clock, all state on rising edge
//  rst               in   1       asynchronous, active-high reset
//  flush_i           in   1       exception flush from stall_flush_controller; aborts divide
//  start_i           in   1       EX holds a DIV/DIVU (level, held while EX is stalled)
//  signed_i          in   1       1=DIV (two's complement), 0=DIVU
//  dividend_i        in   DATA_W  rs value
//  divisor_i         in   DATA_W  rt value
//  pipe_stall_i      in   1       inst_stall | data_stall (excludes this unit's stall)
//  ex_ok_o           out  1       0 = divide pending, pipeline must stall
//  result_valid_o    out  1       quotient/remainder valid (state DONE)
//  quotient_o        out  DATA_W  LO write value
//  remainder_o       out  DATA_W  HI write value
// BEHAVIOUR
//  Reset: state=IDLE, counter=0.
//    Outputs after reset: quotient_o=0, remainder_o=0, result_valid_o=0, ex_ok_o=1.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE->BUSY when start_i & ~flush_i & divisor_i!=0.
//    Latch |dividend|, |divisor| (abs only if signed_i), quotient sign, remainder sign; counter=0.
//  IDLE->DONE when start_i & ~flush_i & divisor_i==0.
//    quotient=all ones, remainder=dividend_i; no iterations.
//  BUSY: one shift-subtract step per cycle on the {rem,quo} 2*DATA_W register.
//    Step: trial = rem_shifted - divisor; if trial>=0, keep it and set the quotient bit.
//    After the DATA_W-th step, go to DONE and apply sign fixup.
//    Fixup: negate quotient if operand signs differ; remainder takes the dividend's sign.
//  DONE: quotient_o/remainder_o held stable, result_valid_o=1.
//    Leave to IDLE when pipe_stall_i=0 (EX advances this cycle).
//    Otherwise stay in DONE; no re-launch although start_i is still high.
//  ex_ok_o (combinational) = flush_i | ~start_i | (state==DONE).
//    It is low in the launch cycle itself.
//    Latency: start seen in IDLE -> DONE DATA_W+1 cycles later -> ex_ok_o=1.
//  Back-to-back: next DIV enters EX the cycle after DONE->IDLE; it launches that cycle.
//  flush_i (synchronous, highest priority after rst): any state -> IDLE next edge.
//    The counter is cleared; result_valid_o=0 next cycle.
//  Edge cases:
//    Signed 0x80000000 / -1: quotient 0x80000000, remainder 0 (natural wrap, no trap).
//    Operands are sampled only at launch; input changes during BUSY are ignored.
//  rst asserted mid-BUSY: immediate return to reset values.
//  start_i dropping during BUSY (no flush): the divide completes to DONE.
//    It then returns to IDLE on the first cycle with pipe_stall_i=0.
// TESTING
//  1. DIVU 100/7: ex_ok_o=0 for DATA_W+1 cycles, then quotient=14, remainder=2, ex_ok_o=1.
//  2. DIV 0xFFFFFFF9(-7)/2 -> quotient 0xFFFFFFFD(-3), remainder 0xFFFFFFFF(-1).
//     DIV 7/0xFFFFFFFE -> quotient -3, remainder 1.
//  3. DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
//     DIVU 5/0 -> DONE in 1 cycle, quotient 0xFFFFFFFF, remainder 5.
//  4. flush_i at cycle 10 of BUSY -> IDLE next cycle, ex_ok_o=1 during flush.
//     A new DIVU 9/3 afterwards -> quotient 3, remainder 0.
//  5. At DONE, hold pipe_stall_i=1 for 5 cycles -> results stable, no relaunch.
//     Drop pipe_stall_i -> IDLE; a second start_i relaunches.
//  6. rst pulse mid-BUSY -> all outputs at reset values asynchronously; next divide correct.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//                Holds the pipeline via ex_ok_o while a divide is in flight,
//                then presents quotient (LO) and remainder (HI) until EX
//                advances. An exception flush cancels any divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              pipe_stall_i,
  output logic              ex_ok_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  // Iteration counter runs 0 .. DATA_W-1, one step per BUSY cycle.
  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;

  // Working registers: r_rem is the partial remainder, r_quo holds the
  // not-yet-consumed dividend bits in its top and the quotient bits shifted
  // in at the bottom. After completion they hold the final signed results.
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;

  // Launch-time operand conditioning.
  logic              w_launch;
  logic              w_div_zero;
  logic              w_dvd_neg;
  logic              w_dvs_neg;
  logic [DATA_W-1:0] w_dvd_abs;
  logic [DATA_W-1:0] w_dvs_abs;

  // One restoring step.
  logic [DATA_W:0]   w_shifted;
  logic              w_ge;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_rem_step;
  logic [DATA_W-1:0] w_quo_step;
  logic              w_last;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

  // Launch decision and magnitude extraction for the incoming operands.
  always_comb begin
    w_launch   = (r_state == S_IDLE) && start_i && !flush_i;
    w_div_zero = (divisor_i == '0);
    w_dvd_neg  = signed_i && dividend_i[DATA_W-1];
    w_dvs_neg  = signed_i && divisor_i[DATA_W-1];
    w_dvd_abs  = w_dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
    w_dvs_abs  = w_dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
  end

  // Shift-subtract step; the shifted remainder needs one extra bit because
  // 2*rem+1 can exceed DATA_W bits before the subtraction brings it back.
  always_comb begin
    w_shifted  = {r_rem, r_quo[DATA_W-1]};
    w_ge       = (w_shifted >= {1'b0, r_dvs});
    w_diff     = w_shifted[DATA_W-1:0] - r_dvs;
    w_rem_step = w_ge ? w_diff : w_shifted[DATA_W-1:0];
    w_quo_step = {r_quo[DATA_W-2:0], w_ge};
    w_last     = (r_cnt == CNT_LAST);
    // Sign fixup: quotient negative when operand signs differ, remainder
    // follows the dividend. The most-negative / -1 case wraps naturally.
    w_quo_fix  = r_neg_q ? (~w_quo_step + 1'b1) : w_quo_step;
    w_rem_fix  = r_neg_r ? (~w_rem_step + 1'b1) : w_rem_step;
  end

  // Next-state selection; flush overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_state_nxt = w_div_zero ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (!pipe_stall_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Iteration counter: cleared on launch or flush, advances in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (flush_i || w_launch) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Datapath: load operands at launch, step while busy, fix signs on the
  // final step. Nothing moves in DONE so the results stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_launch) begin
      if (w_div_zero) begin
        r_quo <= '1;
        r_rem <= dividend_i;
      end else begin
        r_quo   <= w_dvd_abs;
        r_rem   <= '0;
        r_dvs   <= w_dvs_abs;
        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
        r_neg_r <= w_dvd_neg;
      end
    end else if ((r_state == S_BUSY) && !flush_i) begin
      if (w_last) begin
        r_quo <= w_quo_fix;
        r_rem <= w_rem_fix;
      end else begin
        r_quo <= w_quo_step;
        r_rem <= w_rem_step;
      end
    end
  end

  // Stall request and result presentation.
  always_comb begin
    ex_ok_o        = flush_i || !start_i || (r_state == S_DONE);
    result_valid_o = (r_state == S_DONE);
    quotient_o     = r_quo;
    remainder_o    = r_rem;
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit against an arithmetic
//                reference model (native division, truncation toward zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int DATA_W  = 32;
  localparam int LAT_DIV = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              start_i;
  logic              signed_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic              pipe_stall_i;
  logic              ex_ok_o;
  logic              result_valid_o;
  logic [DATA_W-1:0] quotient_o;
  logic [DATA_W-1:0] remainder_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  div_unit #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .pipe_stall_i  (pipe_stall_i),
    .ex_ok_o       (ex_ok_o),
    .result_valid_o(result_valid_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o)
  );

  always #5 clk = ~clk;

  // Reference: MIPS-style DIV/DIVU with divide-by-zero convention.
  function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sg) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  // Drive one divide with pipe_stall_i low; scramble operands while busy.
  task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output int low, output logic eo, output bit ok);
    ok  = 1'b0;
    low = 0;
    @(posedge clk); #1;
    signed_i   = sg;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (ex_ok_o === 1'b0) low++;
      if (i >= 1) begin
        dividend_i = $urandom;
        divisor_i  = $urandom;
      end
    end
    q  = quotient_o;
    r  = remainder_o;
    eo = ex_ok_o;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0; pipe_stall_i = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (quotient_o !== 32'd0) $display("FAIL reset_q: got %h want 0", quotient_o); else pass_cnt++;
    total_cnt++; if (remainder_o !== 32'd0) $display("FAIL reset_r: got %h want 0", remainder_o); else pass_cnt++;
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", result_valid_o); else pass_cnt++;
    total_cnt++; if (ex_ok_o !== 1'b1) $display("FAIL reset_ex_ok: got %b want 1", ex_ok_o); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_divu_basic;
    logic [31:0] q, r; int low; logic eo; bit ok;
    run_div(1'b0, 32'd100, 32'd7, q, r, low, eo, ok);
    total_cnt++; if (!ok) $display("FAIL divu_done: got timeout want done"); else pass_cnt++;
    total_cnt++; if (low != LAT_DIV) $display("FAIL divu_latency: got %0d want %0d", low, LAT_DIV); else pass_cnt++;
    total_cnt++; if (q !== 32'd14) $display("FAIL divu_q: got %h want %h", q, 32'd14); else pass_cnt++;
    total_cnt++; if (r !== 32'd2) $display("FAIL divu_r: got %h want %h", r, 32'd2); else pass_cnt++;
    total_cnt++; if (eo !== 1'b1) $display("FAIL divu_ex_ok: got %b want 1", eo); else pass_cnt++;
  endtask

  task automatic test_signed;
    logic [31:0] ta [4]; logic [31:0] tb [4]; logic [31:0] tq [4]; logic [31:0] tr [4];
    logic [31:0] q, r; int low; logic eo; bit ok;
    ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;          tq[0] = 32'hFFFF_FFFD; tr[0] = 32'hFFFF_FFFF;
    ta[1] = 32'd7;         tb[1] = 32'hFFFF_FFFE;  tq[1] = 32'hFFFF_FFFD; tr[1] = 32'd1;
    ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;  tq[2] = 32'h8000_0000; tr[2] = 32'd0;
    ta[3] = 32'hFFFF_FF9C; tb[3] = 32'hFFFF_FFF9;  tq[3] = 32'd14;        tr[3] = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      run_div(1'b1, ta[i], tb[i], q, r, low, eo, ok);
      total_cnt++;
      if (!ok || q !== tq[i] || r !== tr[i] || low != LAT_DIV)
        $display("FAIL signed_%0d: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", i, q, r, low, tq[i], tr[i], LAT_DIV);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] q, r; int low; logic eo; bit ok;
    run_div(1'b0, 32'd5, 32'd0, q, r, low, eo, ok);
    total_cnt++;
    if (!ok || q !== 32'hFFFF_FFFF || r !== 32'd5 || low != 1)
      $display("FAIL divu_zero: got q=%h r=%h lat=%0d want q=ffffffff r=00000005 lat=1", q, r, low);
    else pass_cnt++;
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, q, r, low, eo, ok);
    total_cnt++;
    if (!ok || q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF0 || low != 1)
      $display("FAIL div_zero: got q=%h r=%h lat=%0d want q=ffffffff r=fffffff0 lat=1", q, r, low);
    else pass_cnt++;
  endtask

  task automatic test_flush;
    logic [31:0] q, r; int low; logic eo; bit ok; bit seen;
    @(posedge clk); #1;
    signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    total_cnt++; if (ex_ok_o !== 1'b1) $display("FAIL flush_ex_ok: got %b want 1", ex_ok_o); else pass_cnt++;
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL flush_valid: got %b want 0", result_valid_o); else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid_o !== 1'b0) seen = 1'b1;
    end
    total_cnt++; if (seen) $display("FAIL flush_no_done: got done after flush want idle"); else pass_cnt++;
    run_div(1'b0, 32'd9, 32'd3, q, r, low, eo, ok);
    total_cnt++;
    if (!ok || q !== 32'd3 || r !== 32'd0 || low != LAT_DIV)
      $display("FAIL flush_next: got q=%h r=%h lat=%0d want q=3 r=0 lat=%0d", q, r, low, LAT_DIV);
    else pass_cnt++;
  endtask

  task automatic test_done_hold;
    bit ok;
    pipe_stall_i = 1'b1;
    @(posedge clk); #1;
    signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd6; start_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid_o === 1'b1) begin ok = 1'b1; break; end
    end
    total_cnt++; if (!ok) $display("FAIL hold_done: got timeout want done"); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (result_valid_o !== 1'b1 || ex_ok_o !== 1'b1 || quotient_o !== 32'd8 || remainder_o !== 32'd2)
        $display("FAIL hold_stable_%0d: got v=%b ok=%b q=%h r=%h want v=1 ok=1 q=8 r=2",
                 i, result_valid_o, ex_ok_o, quotient_o, remainder_o);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    pipe_stall_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd10;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (result_valid_o !== 1'b0 || ex_ok_o !== 1'b0)
      $display("FAIL hold_relaunch: got v=%b ok=%b want v=0 ok=0", result_valid_o, ex_ok_o);
    else pass_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid_o === 1'b1) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok || quotient_o !== 32'd7 || remainder_o !== 32'd7)
      $display("FAIL hold_second: got q=%h r=%h done=%b want q=7 r=7 done=1", quotient_o, remainder_o, ok);
    else pass_cnt++;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic test_rst_mid_busy;
    logic [31:0] q, r, eq, er; int low; logic eo; bit ok;
    @(posedge clk); #1;
    signed_i = 1'b0; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h0000_1234; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1; start_i = 1'b0;
    #1;
    total_cnt++;
    if (quotient_o !== 32'd0 || remainder_o !== 32'd0 || result_valid_o !== 1'b0 || ex_ok_o !== 1'b1)
      $display("FAIL rst_async: got q=%h r=%h v=%b ok=%b want q=0 r=0 v=0 ok=1",
               quotient_o, remainder_o, result_valid_o, ex_ok_o);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    model(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, eq, er);
    run_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, q, r, low, eo, ok);
    total_cnt++;
    if (!ok || q !== eq || r !== er || low != LAT_DIV)
      $display("FAIL rst_next: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", q, r, low, eq, er, LAT_DIV);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, eq, er; int low, elat; logic eo; bit ok, sg;
    for (int n = 0; n < 40; n++) begin
      sg = ($urandom_range(0, 1) == 1);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      model(sg, a, b, eq, er);
      elat = (b == 32'd0) ? 1 : LAT_DIV;
      run_div(sg, a, b, q, r, low, eo, ok);
      total_cnt++;
      if (!ok || q !== eq || r !== er || low != elat || eo !== 1'b1)
        $display("FAIL random_%0d: sg=%b a=%h b=%h got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                 n, sg, a, b, q, r, low, eq, er, elat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_flush();
    test_done_hold();
    test_rst_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
